// File: rtl/pipe_bubble_ctrl.sv
// Bubble/stall controller between the Control unit and the ID/EX register.
// It passes or NOPs the control bundle, sequences stalls, defers flushes and counts bubbles.
module pipe_bubble_ctrl #(
    parameter int                CTRL_W   = 8,
    parameter logic [CTRL_W-1:0] NOP_CTRL = '0,
    parameter int                LEN_W    = 3,
    parameter int                STAT_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic              hazard_i,
    input  logic              stall_req_i,
    input  logic [LEN_W-1:0]  stall_len_i,
    input  logic              flush_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic              pc_write_o,
    output logic              ifid_write_o,
    output logic              ifid_flush_o,
    output logic              busy_o,
    output logic [STAT_W-1:0] bubble_cnt_o
);

    typedef enum logic {RUN, STALL} state_t;

    state_t            fsmReg;
    logic [LEN_W-1:0]  cntReg;
    logic              flushPendReg;
    logic [STAT_W-1:0] bubbleCntReg;

    logic inRun;
    logic stallStart;
    logic bubble;

    assign inRun      = (fsmReg == RUN);
    assign stallStart = inRun && stall_req_i && (stall_len_i != '0);
    assign bubble     = !inRun || stallStart || hazard_i;

    // Outputs are forced to their idle values for as long as reset is held.
    always_comb begin
        ctrl_o       = NOP_CTRL;
        pc_write_o   = 1'b0;
        ifid_write_o = 1'b0;
        ifid_flush_o = 1'b0;
        busy_o       = 1'b0;
        if (rst_i) begin
            busy_o = !inRun;
            if (!bubble) begin
                ctrl_o       = ctrl_i;
                pc_write_o   = 1'b1;
                ifid_write_o = 1'b1;
                ifid_flush_o = flush_i || flushPendReg;
            end
        end
    end

    assign bubble_cnt_o = bubbleCntReg;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fsmReg       <= RUN;
            cntReg       <= '0;
            flushPendReg <= 1'b0;
            bubbleCntReg <= '0;
        end else begin
            case (fsmReg)
                RUN: begin
                    // A length-1 request is a single bubble with no STALL visit.
                    if (stallStart && stall_len_i != LEN_W'(1)) begin
                        fsmReg <= STALL;
                        cntReg <= stall_len_i - LEN_W'(1);
                    end
                end
                STALL: begin
                    cntReg <= cntReg - LEN_W'(1);
                    if (cntReg == LEN_W'(1))
                        fsmReg <= RUN;
                end
                default: begin
                    fsmReg <= RUN;
                    cntReg <= '0;
                end
            endcase

            // A flush seen during bubbles is held until the first real RUN cycle applies it.
            if (bubble && flush_i)
                flushPendReg <= 1'b1;
            else if (!bubble)
                flushPendReg <= 1'b0;

            if (bubble && bubbleCntReg != {STAT_W{1'b1}})
                bubbleCntReg <= bubbleCntReg + STAT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_bubble_ctrl.sv
// Directed bench for pipe_bubble_ctrl: a default instance plus a 4-bit-counter instance
// that shares the same stimulus and is used for the saturation check.
module tb_pipe_bubble_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic [7:0] ctrl_i = 8'h00;
    logic       hazard_i = 1'b0;
    logic       stall_req_i = 1'b0;
    logic [2:0] stall_len_i = 3'd0;
    logic       flush_i = 1'b0;

    logic [7:0]  ctrl_o;
    logic        pc_write_o, ifid_write_o, ifid_flush_o, busy_o;
    logic [15:0] bubble_cnt_o;

    logic [7:0] ctrlB;
    logic       pcWriteB, ifidWriteB, ifidFlushB, busyB;
    logic [3:0] bubbleCntB;

    int total = 0;
    int bad   = 0;

    pipe_bubble_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i), .ctrl_i(ctrl_i), .hazard_i(hazard_i),
        .stall_req_i(stall_req_i), .stall_len_i(stall_len_i), .flush_i(flush_i),
        .ctrl_o(ctrl_o), .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o),
        .ifid_flush_o(ifid_flush_o), .busy_o(busy_o), .bubble_cnt_o(bubble_cnt_o)
    );

    pipe_bubble_ctrl #(.STAT_W(4)) dutSat (
        .clk_i(clk_i), .rst_i(rst_i), .ctrl_i(ctrl_i), .hazard_i(hazard_i),
        .stall_req_i(stall_req_i), .stall_len_i(stall_len_i), .flush_i(flush_i),
        .ctrl_o(ctrlB), .pc_write_o(pcWriteB), .ifid_write_o(ifidWriteB),
        .ifid_flush_o(ifidFlushB), .busy_o(busyB), .bubble_cnt_o(bubbleCntB)
    );

    always #5 clk_i = ~clk_i;

    // Inputs change 1 time unit after the rising edge; outputs are sampled 3 units later.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        ctrl_i = 8'hA5;
        #2;
        total++; if (ctrl_o !== 8'h00) begin bad++; $display("FAIL rst_ctrl got=%h exp=00", ctrl_o); end
        total++; if (pc_write_o !== 1'b0) begin bad++; $display("FAIL rst_pcw got=%b exp=0", pc_write_o); end
        total++; if (ifid_write_o !== 1'b0) begin bad++; $display("FAIL rst_ifidw got=%b exp=0", ifid_write_o); end
        total++; if (bubble_cnt_o !== 16'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", bubble_cnt_o); end
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        total++; if (ctrl_o !== 8'hA5) begin bad++; $display("FAIL rel_ctrl got=%h exp=a5", ctrl_o); end
        total++; if (pc_write_o !== 1'b1 || ifid_write_o !== 1'b1) begin bad++;
            $display("FAIL rel_write got=%b%b exp=11", pc_write_o, ifid_write_o); end
        $display("reset: ctrl=%h pcw=%b ifidw=%b", ctrl_o, pc_write_o, ifid_write_o);
    endtask

    task automatic test_load_use();
        step();
        ctrl_i = 8'h3C; hazard_i = 1'b1;
        #3;
        total++; if (ctrl_o !== 8'h00) begin bad++; $display("FAIL lu_ctrl got=%h exp=00", ctrl_o); end
        total++; if (pc_write_o !== 1'b0 || ifid_write_o !== 1'b0) begin bad++;
            $display("FAIL lu_write got=%b%b exp=00", pc_write_o, ifid_write_o); end
        step();
        hazard_i = 1'b0;
        #3;
        total++; if (ctrl_o !== 8'h3C) begin bad++; $display("FAIL lu_pass got=%h exp=3c", ctrl_o); end
        total++; if (bubble_cnt_o !== 16'd1) begin bad++; $display("FAIL lu_cnt got=%0d exp=1", bubble_cnt_o); end
        $display("load_use: ctrl=%h cnt=%0d", ctrl_o, bubble_cnt_o);
    endtask

    task automatic test_stall();
        step();
        ctrl_i = 8'h5A; stall_req_i = 1'b1; stall_len_i = 3'd4;
        #3;
        total++; if (ctrl_o !== 8'h00 || busy_o !== 1'b0) begin bad++;
            $display("FAIL st_c1 got ctrl=%h busy=%b exp ctrl=00 busy=0", ctrl_o, busy_o); end
        for (int c = 2; c <= 4; c++) begin
            step();
            stall_req_i = 1'b0; stall_len_i = 3'd0;
            #3;
            total++; if (ctrl_o !== 8'h00 || busy_o !== 1'b1 || pc_write_o !== 1'b0) begin bad++;
                $display("FAIL st_c%0d got ctrl=%h busy=%b pcw=%b exp ctrl=00 busy=1 pcw=0",
                         c, ctrl_o, busy_o, pc_write_o); end
        end
        step();
        #3;
        total++; if (ctrl_o !== 8'h5A || busy_o !== 1'b0 || pc_write_o !== 1'b1) begin bad++;
            $display("FAIL st_c5 got ctrl=%h busy=%b pcw=%b exp ctrl=5a busy=0 pcw=1",
                     ctrl_o, busy_o, pc_write_o); end
        total++; if (bubble_cnt_o !== 16'd5) begin bad++; $display("FAIL st_cnt got=%0d exp=5", bubble_cnt_o); end
        $display("stall4: ctrl=%h cnt=%0d", ctrl_o, bubble_cnt_o);
    endtask

    task automatic test_deferred_flush();
        step();
        stall_req_i = 1'b1; stall_len_i = 3'd4;
        #3;
        total++; if (ifid_flush_o !== 1'b0) begin bad++; $display("FAIL df_c1 got=%b exp=0", ifid_flush_o); end
        step();
        stall_req_i = 1'b0; stall_len_i = 3'd0; flush_i = 1'b1;
        #3;
        total++; if (ifid_flush_o !== 1'b0) begin bad++; $display("FAIL df_c2 got=%b exp=0", ifid_flush_o); end
        for (int c = 3; c <= 4; c++) begin
            step();
            flush_i = 1'b0;
            #3;
            total++; if (ifid_flush_o !== 1'b0) begin bad++; $display("FAIL df_c%0d got=%b exp=0", c, ifid_flush_o); end
        end
        step();
        #3;
        total++; if (ifid_flush_o !== 1'b1 || pc_write_o !== 1'b1) begin bad++;
            $display("FAIL df_c5 got flush=%b pcw=%b exp flush=1 pcw=1", ifid_flush_o, pc_write_o); end
        step();
        #3;
        total++; if (ifid_flush_o !== 1'b0) begin bad++; $display("FAIL df_c6 got=%b exp=0", ifid_flush_o); end
        total++; if (bubble_cnt_o !== 16'd9) begin bad++; $display("FAIL df_cnt got=%0d exp=9", bubble_cnt_o); end
        $display("deferred_flush: cnt=%0d", bubble_cnt_o);
    endtask

    task automatic test_simultaneous();
        step();
        ctrl_i = 8'h77; hazard_i = 1'b1; flush_i = 1'b1;
        #3;
        total++; if (ctrl_o !== 8'h00 || ifid_flush_o !== 1'b0) begin bad++;
            $display("FAIL sim_c1 got ctrl=%h flush=%b exp ctrl=00 flush=0", ctrl_o, ifid_flush_o); end
        step();
        hazard_i = 1'b0; flush_i = 1'b0;
        #3;
        total++; if (ctrl_o !== 8'h77 || ifid_flush_o !== 1'b1) begin bad++;
            $display("FAIL sim_c2 got ctrl=%h flush=%b exp ctrl=77 flush=1", ctrl_o, ifid_flush_o); end
        step();
        #3;
        total++; if (ifid_flush_o !== 1'b0) begin bad++; $display("FAIL sim_c3 got=%b exp=0", ifid_flush_o); end
        step();
        stall_req_i = 1'b1; stall_len_i = 3'd0;
        #3;
        total++; if (ctrl_o !== 8'h77 || pc_write_o !== 1'b1 || busy_o !== 1'b0) begin bad++;
            $display("FAIL len0 got ctrl=%h pcw=%b busy=%b exp ctrl=77 pcw=1 busy=0", ctrl_o, pc_write_o, busy_o); end
        step();
        stall_req_i = 1'b0;
        #3;
        total++; if (bubble_cnt_o !== 16'd10) begin bad++; $display("FAIL sim_cnt got=%0d exp=10", bubble_cnt_o); end
        $display("simultaneous: cnt=%0d", bubble_cnt_o);
    endtask

    task automatic test_reset_midstall();
        step();
        ctrl_i = 8'h99; stall_req_i = 1'b1; stall_len_i = 3'd7;
        #3;
        total++; if (ctrl_o !== 8'h00) begin bad++; $display("FAIL rm_c1 got=%h exp=00", ctrl_o); end
        step();
        stall_req_i = 1'b0; stall_len_i = 3'd0; flush_i = 1'b1;
        #1;
        total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL rm_busy got=%b exp=1", busy_o); end
        rst_i = 1'b0;
        #1;
        total++; if (ctrl_o !== 8'h00 || pc_write_o !== 1'b0 || ifid_flush_o !== 1'b0 || busy_o !== 1'b0) begin bad++;
            $display("FAIL rm_rst got ctrl=%h pcw=%b flush=%b busy=%b exp 00 0 0 0",
                     ctrl_o, pc_write_o, ifid_flush_o, busy_o); end
        total++; if (bubble_cnt_o !== 16'd0 || bubbleCntB !== 4'd0) begin bad++;
            $display("FAIL rm_cnt got=%0d/%0d exp=0/0", bubble_cnt_o, bubbleCntB); end
        flush_i = 1'b0;
        step();
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        total++; if (ctrl_o !== 8'h99 || busy_o !== 1'b0 || ifid_flush_o !== 1'b0 || pc_write_o !== 1'b1) begin bad++;
            $display("FAIL rm_rel got ctrl=%h busy=%b flush=%b pcw=%b exp 99 0 0 1",
                     ctrl_o, busy_o, ifid_flush_o, pc_write_o); end
        $display("reset_midstall: ctrl=%h busy=%b flush=%b", ctrl_o, busy_o, ifid_flush_o);
    endtask

    task automatic test_saturation();
        step();
        hazard_i = 1'b1;
        repeat (14) step();
        total++; if (bubbleCntB !== 4'hE || bubble_cnt_o !== 16'd14) begin bad++;
            $display("FAIL sat14 got=%h/%0d exp=e/14", bubbleCntB, bubble_cnt_o); end
        repeat (6) step();
        total++; if (bubbleCntB !== 4'hF) begin bad++; $display("FAIL sat20 got=%h exp=f", bubbleCntB); end
        total++; if (bubble_cnt_o !== 16'd20) begin bad++; $display("FAIL cnt20 got=%0d exp=20", bubble_cnt_o); end
        hazard_i = 1'b0;
        $display("saturation: cnt4=%h cnt16=%0d", bubbleCntB, bubble_cnt_o);
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_stall();
        test_deferred_flush();
        test_simultaneous();
        test_reset_midstall();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
